// File: rtl/sh_dmac_multi.sv
// sh_dmac_multi -- parametrised multi-channel, dual-address DMA controller.
//
// Each transfer block reads N units from the source into a small buffer,
// then writes them out to the destination. N is 1 for single-unit mode, or
// min(TCR, FIFO_DEPTH) when block burst is on. Channels are picked with a
// fixed-priority or round-robin arbiter. Misaligned word/long addresses are
// caught before any bus beat starts.
//
// Ports
//   CLK, RST_N        clock; asynchronous active-low reset
//   NMI_N             active-low NMI, sampled every cycle; sets DMAOR.NMIF
//   DREQ / DACK       per-channel external request / read-beat acknowledge
//   REG_A/DI/DO/WE/REQ  longword register port; REG_DO is registered
//   MA/MDO/MDI/MBA/MWE/MREQ/MWAIT  master bus (big-endian byte enables)
//   IRQ               per-channel TE & IE
module sh_dmac_multi #(
  parameter int CH_NUM     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TCR_W      = 24
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              NMI_N,
  input  logic [CH_NUM-1:0] DREQ,
  output logic [CH_NUM-1:0] DACK,
  input  logic [8:0]        REG_A,
  input  logic [31:0]       REG_DI,
  output logic [31:0]       REG_DO,
  input  logic              REG_WE,
  input  logic              REG_REQ,
  output logic [31:0]       MA,
  output logic [31:0]       MDO,
  input  logic [31:0]       MDI,
  output logic [3:0]        MBA,
  output logic              MWE,
  output logic              MREQ,
  input  logic              MWAIT,
  output logic [CH_NUM-1:0] IRQ
);

  localparam int CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_READ, S_GAP, S_WRITE} state_e;

  // Field layout matches the CHCR register bits 12..0.
  typedef struct packed {
    logic       bm;
    logic       dl;
    logic       ds;
    logic       ar;
    logic [1:0] dm;
    logic [1:0] sm;
    logic [1:0] ts;
    logic       ie;
    logic       te;
    logic       de;
  } chcr_t;

  // ---------------------------------------------------------------------
  // Helpers for unit size / lane handling (big-endian: byte 0 on [31:24]).
  // ---------------------------------------------------------------------
  function automatic logic [31:0] step_addr(input logic [31:0] addr,
                                            input logic [1:0]  mode,
                                            input logic [1:0]  ts);
    logic [31:0] size;
    size = ts[1] ? 32'd4 : (ts[0] ? 32'd2 : 32'd1);
    case (mode)
      2'b01:   step_addr = addr + size;
      2'b10:   step_addr = addr - size;
      default: step_addr = addr;
    endcase
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] data,
                                               input logic [1:0]  a,
                                               input logic [1:0]  ts);
    if (ts[1])      lane_extract = data;
    else if (ts[0]) lane_extract = a[1] ? {16'h0, data[15:0]} : {16'h0, data[31:16]};
    else begin
      case (a)
        2'd0:    lane_extract = {24'h0, data[31:24]};
        2'd1:    lane_extract = {24'h0, data[23:16]};
        2'd2:    lane_extract = {24'h0, data[15:8]};
        default: lane_extract = {24'h0, data[7:0]};
      endcase
    end
  endfunction

  function automatic logic [3:0] lane_enables(input logic [1:0] a, input logic [1:0] ts);
    if (ts[1])      lane_enables = 4'b1111;
    else if (ts[0]) lane_enables = a[1] ? 4'b0011 : 4'b1100;
    else            lane_enables = 4'b1000 >> a;
  endfunction

  function automatic logic [31:0] replicate(input logic [31:0] unit, input logic [1:0] ts);
    if (ts[1])      replicate = unit;
    else if (ts[0]) replicate = {2{unit[15:0]}};
    else            replicate = {4{unit[7:0]}};
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [31:0]       sar_q [CH_NUM];
  logic [31:0]       sar_d [CH_NUM];
  logic [31:0]       dar_q [CH_NUM];
  logic [31:0]       dar_d [CH_NUM];
  logic [TCR_W-1:0]  tcr_q [CH_NUM];
  logic [TCR_W-1:0]  tcr_d [CH_NUM];
  chcr_t             chcr_q [CH_NUM];
  chcr_t             chcr_d [CH_NUM];
  logic              dme_q, dme_d, nmif_q, nmif_d, ae_q, ae_d, pr_q, pr_d;
  logic [CH_NUM-1:0] pend_q, pend_d, dreq_q;
  logic [CH_W-1:0]   act_q, act_d, rr_q, rr_d;
  logic [1:0]        ts_q, ts_d, sm_q, sm_d, dm_q, dm_d;
  logic [CNT_W-1:0]  n_q, n_d, beat_q, beat_d;
  logic [31:0]       reg_do_q, reg_do_d;
  logic [31:0]       fifo_q [FIFO_DEPTH];
  logic              fifo_we;

  // Active-channel views.
  logic [31:0]      act_sar, act_dar;
  logic [TCR_W-1:0] act_tcr;
  chcr_t            act_chcr;
  logic [PTR_W-1:0] fifo_idx;
  assign act_sar  = sar_q[act_q];
  assign act_dar  = dar_q[act_q];
  assign act_tcr  = tcr_q[act_q];
  assign act_chcr = chcr_q[act_q];
  // Beats and buffer slots advance together, so the beat counter doubles
  // as both the push and the pop pointer.
  assign fifo_idx = beat_q[PTR_W-1:0];

  // ---------------------------------------------------------------------
  // Request sources and eligibility
  // ---------------------------------------------------------------------
  logic [CH_NUM-1:0] req, elig;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    req  = '0;
    elig = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (chcr_q[i].ar)      req[i] = 1'b1;
      else if (chcr_q[i].ds) req[i] = pend_q[i];
      else                   req[i] = chcr_q[i].dl ? DREQ[i] : ~DREQ[i];
      elig[i] = dme_q & chcr_q[i].de & ~chcr_q[i].te & ~nmif_q & ~ae_q & req[i];
    end
  end

  // ---------------------------------------------------------------------
  // Arbiter: fixed priority from 0, or round-robin from last grant + 1.
  // ---------------------------------------------------------------------
  logic            grant_vld;
  logic [CH_W-1:0] grant_ch;
  int              arb_start, arb_idx;

  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    arb_idx   = 0;
    arb_start = pr_q ? (int'(rr_q) + 1) % CH_NUM : 0;
    for (int i = 0; i < CH_NUM; i++) begin
      arb_idx = (arb_start + i) % CH_NUM;
      if (!grant_vld && elig[arb_idx]) begin
        grant_vld = 1'b1;
        grant_ch  = CH_W'(arb_idx);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Block setup values evaluated in ARB
  // ---------------------------------------------------------------------
  logic             misalign;
  logic [CNT_W-1:0] blk_len;

  always_comb begin
    misalign = ((act_chcr.ts == 2'b01) && (act_sar[0] || act_dar[0])) ||
               (act_chcr.ts[1] && ((act_sar[1:0] != 2'b00) || (act_dar[1:0] != 2'b00)));
    if (!act_chcr.bm)
      blk_len = CNT_W'(1);
    else if ((act_tcr == '0) || (act_tcr >= TCR_W'(FIFO_DEPTH)))
      blk_len = CNT_W'(FIFO_DEPTH);
    else
      blk_len = act_tcr[CNT_W-1:0];
  end

  // ---------------------------------------------------------------------
  // Register port decode
  // ---------------------------------------------------------------------
  logic            reg_aligned, reg_ch_ok, reg_dmaor, reg_locked;
  logic [CH_W-1:0] reg_ch;

  assign reg_aligned = (REG_A[1:0] == 2'b00);
  assign reg_dmaor   = REG_A[8] && (REG_A[7:2] == 6'd0);
  assign reg_ch_ok   = !REG_A[8] && (int'(REG_A[7:4]) < CH_NUM);
  assign reg_ch      = REG_A[4 +: CH_W];
  assign reg_locked  = (state_q != S_IDLE) && (reg_ch == act_q);

  logic beat_done, last_beat;
  assign beat_done = MREQ & ~MWAIT;
  assign last_beat = (beat_q == n_q - CNT_W'(1));

  // ---------------------------------------------------------------------
  // Next-state: register writes first, hardware updates after so that a
  // hardware set wins over a same-cycle software clear.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    sar_d    = sar_q;
    dar_d    = dar_q;
    tcr_d    = tcr_q;
    chcr_d   = chcr_q;
    dme_d    = dme_q;
    nmif_d   = nmif_q;
    ae_d     = ae_q;
    pr_d     = pr_q;
    pend_d   = pend_q;
    act_d    = act_q;
    rr_d     = rr_q;
    ts_d     = ts_q;
    sm_d     = sm_q;
    dm_d     = dm_q;
    n_d      = n_q;
    beat_d   = beat_q;
    reg_do_d = reg_do_q;
    fifo_we  = 1'b0;

    // Software writes.
    if (REG_REQ && REG_WE && reg_aligned) begin
      if (reg_dmaor) begin
        dme_d  = REG_DI[0];
        nmif_d = nmif_q & REG_DI[1];
        ae_d   = ae_q & REG_DI[2];
        pr_d   = REG_DI[3];
      end else if (reg_ch_ok) begin
        case (REG_A[3:2])
          2'd0: if (!reg_locked) sar_d[reg_ch] = REG_DI;
          2'd1: if (!reg_locked) dar_d[reg_ch] = REG_DI;
          2'd2: if (!reg_locked) tcr_d[reg_ch] = REG_DI[TCR_W-1:0];
          default: begin
            // Block-shape fields are latched in ARB, so accepting the write
            // here never disturbs a block already running.
            chcr_d[reg_ch]    = chcr_t'(REG_DI[12:0]);
            chcr_d[reg_ch].te = chcr_q[reg_ch].te & REG_DI[1];
          end
        endcase
      end
    end

    // Software reads (registered).
    if (REG_REQ && !REG_WE) begin
      reg_do_d = '0;
      if (reg_aligned && reg_dmaor) begin
        reg_do_d = {28'h0, pr_q, ae_q, nmif_q, dme_q};
      end else if (reg_aligned && reg_ch_ok) begin
        case (REG_A[3:2])
          2'd0:    reg_do_d = sar_q[reg_ch];
          2'd1:    reg_do_d = dar_q[reg_ch];
          2'd2:    reg_do_d = 32'(tcr_q[reg_ch]);
          default: reg_do_d = 32'(chcr_q[reg_ch]);
        endcase
      end
    end

    // Transfer sequencing.
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          state_d          = S_ARB;
          act_d            = grant_ch;
          rr_d             = grant_ch;
          pend_d[grant_ch] = 1'b0;
        end
      end
      S_ARB: begin
        if (misalign) begin
          ae_d    = 1'b1;
          state_d = S_IDLE;
        end else begin
          ts_d    = act_chcr.ts;
          sm_d    = act_chcr.sm;
          dm_d    = act_chcr.dm;
          n_d     = blk_len;
          beat_d  = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (beat_done) begin
          fifo_we       = 1'b1;
          sar_d[act_q]  = step_addr(act_sar, sm_q, ts_q);
          if (last_beat) begin
            beat_d  = '0;
            state_d = S_GAP;
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end
      S_GAP: state_d = S_WRITE;
      S_WRITE: begin
        if (beat_done) begin
          dar_d[act_q] = step_addr(act_dar, dm_q, ts_q);
          tcr_d[act_q] = act_tcr - TCR_W'(1);
          if (last_beat) begin
            beat_d  = '0;
            state_d = S_IDLE;
            if (act_tcr == TCR_W'(1)) chcr_d[act_q].te = 1'b1;
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Edge-triggered request capture; a new edge beats the grant clear.
    for (int i = 0; i < CH_NUM; i++) begin
      if (!chcr_q[i].ds)
        pend_d[i] = 1'b0;
      else if (chcr_q[i].dl ? (DREQ[i] & ~dreq_q[i]) : (~DREQ[i] & dreq_q[i]))
        pend_d[i] = 1'b1;
    end

    if (!NMI_N) nmif_d = 1'b1;
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      for (int i = 0; i < CH_NUM; i++) begin
        sar_q[i]  <= '0;
        dar_q[i]  <= '0;
        tcr_q[i]  <= '0;
        chcr_q[i] <= '0;
      end
      dme_q    <= 1'b0;
      nmif_q   <= 1'b0;
      ae_q     <= 1'b0;
      pr_q     <= 1'b0;
      pend_q   <= '0;
      dreq_q   <= '0;
      act_q    <= '0;
      rr_q     <= CH_W'(CH_NUM - 1);
      ts_q     <= '0;
      sm_q     <= '0;
      dm_q     <= '0;
      n_q      <= '0;
      beat_q   <= '0;
      reg_do_q <= '0;
    end else begin
      state_q  <= state_d;
      sar_q    <= sar_d;
      dar_q    <= dar_d;
      tcr_q    <= tcr_d;
      chcr_q   <= chcr_d;
      dme_q    <= dme_d;
      nmif_q   <= nmif_d;
      ae_q     <= ae_d;
      pr_q     <= pr_d;
      pend_q   <= pend_d;
      dreq_q   <= DREQ;
      act_q    <= act_d;
      rr_q     <= rr_d;
      ts_q     <= ts_d;
      sm_q     <= sm_d;
      dm_q     <= dm_d;
      n_q      <= n_d;
      beat_q   <= beat_d;
      reg_do_q <= reg_do_d;
    end
  end

  // NOTE: the buffer storage has no reset; every slot is written in READ
  // before WRITE can pop it, and emptiness is carried by the beat counter.
  always_ff @(posedge CLK) begin
    if (fifo_we) fifo_q[fifo_idx] <= lane_extract(MDI, act_sar[1:0], ts_q);
  end

  // ---------------------------------------------------------------------
  // Outputs: driven from registered state, so they hold through MWAIT.
  // ---------------------------------------------------------------------
  always_comb begin
    MREQ = 1'b0;
    MWE  = 1'b0;
    MA   = '0;
    MBA  = '0;
    MDO  = '0;
    DACK = '0;
    case (state_q)
      S_READ: begin
        MREQ = 1'b1;
        MA   = act_sar;
        MBA  = lane_enables(act_sar[1:0], ts_q);
        DACK = CH_NUM'(1) << act_q;
      end
      S_WRITE: begin
        MREQ = 1'b1;
        MWE  = 1'b1;
        MA   = act_dar;
        MBA  = lane_enables(act_dar[1:0], ts_q);
        MDO  = replicate(fifo_q[fifo_idx], ts_q);
      end
      default: ;
    endcase
  end

  always_comb begin
    IRQ = '0;
    for (int i = 0; i < CH_NUM; i++) IRQ[i] = chcr_q[i].te & chcr_q[i].ie;
  end

  assign REG_DO = reg_do_q;

endmodule

// File: tb/tb_sh_dmac_multi.sv
// Directed bench for sh_dmac_multi (CH_NUM=4, FIFO_DEPTH=4, TCR_W=24).
// A bus monitor logs every completed beat; each scenario then compares
// the log and register readback against hand-computed values.
module tb_sh_dmac_multi;

  logic        CLK, RST_N, NMI_N;
  logic [3:0]  DREQ, DACK, IRQ;
  logic [8:0]  REG_A;
  logic [31:0] REG_DI, REG_DO, MA, MDO, MDI;
  logic        REG_WE, REG_REQ, MWE, MREQ, MWAIT;
  logic [3:0]  MBA;

  logic        mdi_force;
  logic [31:0] mdi_const;

  // Memory model: read data is a function of the address unless forced.
  assign MDI = mdi_force ? mdi_const : (MA ^ 32'hDEAD0000);

  sh_dmac_multi #(.CH_NUM(4), .FIFO_DEPTH(4), .TCR_W(24)) dut (
    .CLK(CLK), .RST_N(RST_N), .NMI_N(NMI_N), .DREQ(DREQ), .DACK(DACK),
    .REG_A(REG_A), .REG_DI(REG_DI), .REG_DO(REG_DO), .REG_WE(REG_WE),
    .REG_REQ(REG_REQ), .MA(MA), .MDO(MDO), .MDI(MDI), .MBA(MBA),
    .MWE(MWE), .MREQ(MREQ), .MWAIT(MWAIT), .IRQ(IRQ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mba;
    logic [3:0]  dack;
    int          cyc;
  } beat_t;

  beat_t log_q[$];
  int    cyc;
  int    n_pass;
  int    n_total;

  always @(posedge CLK) cyc <= cyc + 1;

  // MWAIT only changes just after a rising edge, so its value at the
  // falling edge is the one the next rising edge sees.
  always @(negedge CLK) begin
    if (RST_N && MREQ && !MWAIT)
      log_q.push_back('{we: MWE, addr: MA, data: (MWE ? MDO : MDI),
                        mba: MBA, dack: DACK, cyc: cyc});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic reg_write(input logic [8:0] a, input logic [31:0] d);
    REG_A = a; REG_DI = d; REG_WE = 1'b1; REG_REQ = 1'b1;
    @(posedge CLK); #1;
    REG_WE = 1'b0; REG_REQ = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [8:0] a, input logic [31:0] exp);
    REG_A = a; REG_WE = 1'b0; REG_REQ = 1'b1;
    @(posedge CLK); #1;
    REG_REQ = 1'b0;
    check(tag, REG_DO, exp);
  endtask

  task automatic setup_ch(input int ch, input logic [31:0] sar, input logic [31:0] dar,
                          input logic [31:0] tcr, input logic [31:0] chcr);
    reg_write(9'(ch * 16 + 0), sar);
    reg_write(9'(ch * 16 + 4), dar);
    reg_write(9'(ch * 16 + 8), tcr);
    reg_write(9'(ch * 16 + 12), chcr);
  endtask

  task automatic check_beat(input string tag, input int i, input logic we,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] mba, input logic [3:0] dack);
    beat_t b;
    b = (i < log_q.size()) ? log_q[i] : '{we: 1'bx, addr: 'x, data: 'x, mba: 'x, dack: 'x, cyc: 0};
    check($sformatf("%s[%0d].we", tag, i), 32'(b.we), 32'(we));
    check($sformatf("%s[%0d].addr", tag, i), b.addr, addr);
    check($sformatf("%s[%0d].data", tag, i), b.data, data);
    check($sformatf("%s[%0d].mba", tag, i), 32'(b.mba), 32'(mba));
    check($sformatf("%s[%0d].dack", tag, i), 32'(b.dack), 32'(dack));
  endtask

  localparam logic [8:0] DMAOR = 9'h100;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k0;
    cyc = 0; n_pass = 0; n_total = 0;
    RST_N = 1'b0; NMI_N = 1'b1; DREQ = '0; REG_A = '0; REG_DI = '0;
    REG_WE = 1'b0; REG_REQ = 1'b0; MWAIT = 1'b0; mdi_force = 1'b0; mdi_const = '0;
    tick(3);
    RST_N = 1'b1;
    tick(1);

    // ---- Reset state ----
    check("rst_mreq", 32'(MREQ), 0);
    check("rst_ma", MA, 0);
    check("rst_dack", 32'(DACK), 0);
    check("rst_irq", 32'(IRQ), 0);
    check("rst_reg_do", REG_DO, 0);
    check_reg("rst_dmaor", DMAOR, 0);
    check_reg("rst_chcr0", 9'h00C, 0);

    // ---- Ch0 long burst, TCR=6: blocks of 4 then 2 ----
    setup_ch(0, 32'h100, 32'h200, 6, 32'h12B5);
    log_q.delete();
    k0 = cyc;
    reg_write(DMAOR, 32'h1);
    tick(40);
    check("b_count", log_q.size(), 12);
    for (int i = 0; i < 4; i++)
      check_beat("b1r", i, 1'b0, 32'h100 + 4 * i, (32'h100 + 4 * i) ^ 32'hDEAD0000, 4'hF, 4'b0001);
    for (int i = 0; i < 4; i++)
      check_beat("b1w", 4 + i, 1'b1, 32'h200 + 4 * i, (32'h100 + 4 * i) ^ 32'hDEAD0000, 4'hF, 4'b0000);
    for (int i = 0; i < 2; i++)
      check_beat("b2r", 8 + i, 1'b0, 32'h110 + 4 * i, (32'h110 + 4 * i) ^ 32'hDEAD0000, 4'hF, 4'b0001);
    for (int i = 0; i < 2; i++)
      check_beat("b2w", 10 + i, 1'b1, 32'h210 + 4 * i, (32'h110 + 4 * i) ^ 32'hDEAD0000, 4'hF, 4'b0000);
    if (log_q.size() >= 5) begin
      check("latency_first_read", log_q[0].cyc, k0 + 3);
      check("read_back_to_back", log_q[3].cyc - log_q[0].cyc, 3);
      check("read_write_gap", log_q[4].cyc - log_q[3].cyc, 2);
    end else begin
      check("timing_log_size", log_q.size(), 12);
    end
    check_reg("b_tcr", 9'h008, 0);
    check_reg("b_chcr", 9'h00C, 32'h12B7);
    check_reg("b_sar", 9'h000, 32'h118);
    check_reg("b_dar", 9'h004, 32'h218);
    check("b_irq", 32'(IRQ), 32'h1);
    reg_write(9'h00C, 0);
    tick(1);
    check("b_irq_clear", 32'(IRQ), 0);

    // ---- Byte transfer, forced read data, one stalled read beat ----
    reg_write(DMAOR, 0);
    mdi_force = 1'b1; mdi_const = 32'h11223344;
    setup_ch(0, 32'h1003, 32'h2002, 1, 32'h221);
    log_q.delete();
    MWAIT = 1'b1;
    reg_write(DMAOR, 32'h1);
    tick(8);
    check("stall_mreq", 32'(MREQ), 1);
    check("stall_ma", MA, 32'h1003);
    check("stall_no_beat", log_q.size(), 0);
    MWAIT = 1'b0;
    tick(10);
    check("byte_count", log_q.size(), 2);
    check_beat("byte", 0, 1'b0, 32'h1003, 32'h11223344, 4'b0001, 4'b0001);
    check_beat("byte", 1, 1'b1, 32'h2002, 32'h44444444, 4'b0010, 4'b0000);
    check_reg("byte_chcr", 9'h00C, 32'h223);
    check_reg("byte_sar", 9'h000, 32'h1004);
    mdi_force = 1'b0;
    reg_write(9'h00C, 0);

    // ---- Round robin between ch1 and ch2 ----
    reg_write(DMAOR, 0);
    setup_ch(1, 32'h1100, 32'h2100, 2, 32'h2B1);
    setup_ch(2, 32'h1200, 32'h2200, 2, 32'h2B1);
    log_q.delete();
    reg_write(DMAOR, 32'h9);
    tick(40);
    check("rr_count", log_q.size(), 8);
    check_beat("rr", 0, 1'b0, 32'h1100, 32'h1100 ^ 32'hDEAD0000, 4'hF, 4'b0010);
    check_beat("rr", 2, 1'b0, 32'h1200, 32'h1200 ^ 32'hDEAD0000, 4'hF, 4'b0100);
    check_beat("rr", 4, 1'b0, 32'h1104, 32'h1104 ^ 32'hDEAD0000, 4'hF, 4'b0010);
    check_beat("rr", 6, 1'b0, 32'h1204, 32'h1204 ^ 32'hDEAD0000, 4'hF, 4'b0100);

    // ---- Fixed priority: ch1 to completion first ----
    reg_write(DMAOR, 0);
    setup_ch(1, 32'h1100, 32'h2100, 2, 32'h2B1);
    setup_ch(2, 32'h1200, 32'h2200, 2, 32'h2B1);
    log_q.delete();
    reg_write(DMAOR, 32'h1);
    tick(40);
    check("fx_count", log_q.size(), 8);
    check_beat("fx", 0, 1'b0, 32'h1100, 32'h1100 ^ 32'hDEAD0000, 4'hF, 4'b0010);
    check_beat("fx", 2, 1'b0, 32'h1104, 32'h1104 ^ 32'hDEAD0000, 4'hF, 4'b0010);
    check_beat("fx", 4, 1'b0, 32'h1200, 32'h1200 ^ 32'hDEAD0000, 4'hF, 4'b0100);
    check_beat("fx", 6, 1'b0, 32'h1204, 32'h1204 ^ 32'hDEAD0000, 4'hF, 4'b0100);

    // ---- Misaligned word source: AE, then recovery ----
    reg_write(DMAOR, 0);
    reg_write(9'h01C, 0);
    reg_write(9'h02C, 0);
    setup_ch(0, 32'h2001, 32'h3000, 1, 32'h2A9);
    log_q.delete();
    reg_write(DMAOR, 32'h1);
    tick(20);
    check("ae_no_beat", log_q.size(), 0);
    check_reg("ae_dmaor", DMAOR, 32'h5);
    check_reg("ae_chcr", 9'h00C, 32'h2A9);
    reg_write(9'h000, 32'h2002);
    reg_write(DMAOR, 32'h1);
    tick(20);
    check("ae_fix_count", log_q.size(), 2);
    check_beat("aefix", 0, 1'b0, 32'h2002, 32'hDEAD2002, 4'b0011, 4'b0001);
    check_beat("aefix", 1, 1'b1, 32'h3000, 32'h20022002, 4'b1100, 4'b0000);
    check_reg("ae_fix_chcr", 9'h00C, 32'h2AB);

    // ---- NMI during the second read of a 4-beat block ----
    reg_write(DMAOR, 0);
    setup_ch(0, 32'h400, 32'h500, 8, 32'h12B1);
    log_q.delete();
    reg_write(DMAOR, 32'h1);
    for (int i = 0; i < 20 && log_q.size() < 1; i++) tick(1);
    check("nmi_first_read_seen", log_q.size(), 1);
    NMI_N = 1'b0;
    tick(1);
    NMI_N = 1'b1;
    tick(30);
    check("nmi_count", log_q.size(), 8);
    check_beat("nmi", 4, 1'b1, 32'h500, 32'h400 ^ 32'hDEAD0000, 4'hF, 4'b0000);
    check_beat("nmi", 7, 1'b1, 32'h50C, 32'h40C ^ 32'hDEAD0000, 4'hF, 4'b0000);
    check_reg("nmi_dmaor", DMAOR, 32'h3);
    check_reg("nmi_tcr", 9'h008, 4);
    check_reg("nmi_chcr", 9'h00C, 32'h12B1);

    // ---- Ch3 falling-edge DREQ: one unit per edge ----
    DREQ[3] = 1'b1;
    reg_write(DMAOR, 0);
    reg_write(9'h00C, 0);
    setup_ch(3, 32'h600, 32'h700, 5, 32'h4B1);
    log_q.delete();
    reg_write(DMAOR, 32'h1);
    tick(10);
    check("ds_idle_high", log_q.size(), 0);
    DREQ[3] = 1'b0;
    tick(20);
    check("ds_count", log_q.size(), 2);
    check_beat("ds", 0, 1'b0, 32'h600, 32'h600 ^ 32'hDEAD0000, 4'hF, 4'b1000);
    check_beat("ds", 1, 1'b1, 32'h700, 32'h600 ^ 32'hDEAD0000, 4'hF, 4'b0000);
    tick(20);
    check("ds_no_more", log_q.size(), 2);
    check_reg("ds_tcr", 9'h038, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
